// File: rtl/trumpet_voice_scheduler.sv
// Time-multiplexes one Trumpet front/back table pair across NUM_VOICES voices and mixes the returned samples.
// Optional: define TRUMPET_SCHED_SATURATE_EN to saturate the voice sum instead of dividing by NUM_VOICES.
module trumpet_voice_scheduler #(
    parameter int NUM_VOICES  = 8,
    parameter int ACC_WIDTH   = 24,
    parameter int PHASE_WIDTH = 12,
    parameter int AUDIO_WIDTH = 16
) (
    input  logic                          clock,
    input  logic                          reset_l,
    input  logic                          sample_tick,
    input  logic                          note_on,
    input  logic                          note_off,
    input  logic [$clog2(NUM_VOICES)-1:0] voice_id,
    input  logic [ACC_WIDTH-1:0]          increment,
    output logic                          table_state,
    output logic [PHASE_WIDTH-1:0]        table_phase,
    input  logic signed [AUDIO_WIDTH-1:0] table_sample,
    output logic signed [AUDIO_WIDTH-1:0] mix,
    output logic                          mix_valid,
    output logic                          busy,
    output logic                          overrun
);
    localparam int IDX_W = $clog2(NUM_VOICES);
    localparam int SUM_W = AUDIO_WIDTH + IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);
    localparam logic TS_FRONT = 1'b0;
    localparam logic TS_BACK  = 1'b1;

    typedef enum logic [1:0] {V_IDLE, V_FRONT, V_BACK} voice_state_t;
    typedef enum logic [1:0] {S_WAIT, S_ISSUE, S_DRAIN} sched_state_t;

    voice_state_t           vstate_q [NUM_VOICES];
    voice_state_t           vstate_d [NUM_VOICES];
    logic [ACC_WIDTH-1:0]   acc_q    [NUM_VOICES];
    logic [ACC_WIDTH-1:0]   acc_d    [NUM_VOICES];
    logic [ACC_WIDTH-1:0]   inc_q    [NUM_VOICES];
    logic [ACC_WIDTH-1:0]   inc_d    [NUM_VOICES];

    sched_state_t                  fsm_q;
    logic [IDX_W-1:0]              idx_q;
    logic signed [SUM_W-1:0]       sum_q;
    logic                          cap_vld_q;
    logic                          busy_q;
    logic                          overrun_q;
    logic                          mix_valid_q;
    logic signed [AUDIO_WIDTH-1:0] mix_q;
    logic                          table_state_q;
    logic [PHASE_WIDTH-1:0]        table_phase_q;

    logic                          pre_en;
    logic [IDX_W-1:0]              pre_idx;
    logic signed [SUM_W-1:0]       cap_val;
    logic signed [SUM_W-1:0]       sum_next;

    function automatic logic acc_wraps(input logic [ACC_WIDTH-1:0] a, input logic [ACC_WIDTH-1:0] b);
        logic [ACC_WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[ACC_WIDTH];
    endfunction

    function automatic logic signed [AUDIO_WIDTH-1:0] mix_scale(input logic signed [SUM_W-1:0] s);
`ifdef TRUMPET_SCHED_SATURATE_EN
        logic [IDX_W:0] top;
        top = s[SUM_W-1:AUDIO_WIDTH-1];
        if (top == '0 || top == '1)
            return s[AUDIO_WIDTH-1:0];
        else if (s[SUM_W-1])
            return {1'b1, {(AUDIO_WIDTH-1){1'b0}}};
        else
            return {1'b0, {(AUDIO_WIDTH-1){1'b1}}};
`else
        logic signed [SUM_W-1:0] sh;
        sh = s >>> IDX_W;
        return sh[AUDIO_WIDTH-1:0];
`endif
    endfunction

    // Note events are applied after the issue advance so they override it.
    always_comb begin
        for (int v = 0; v < NUM_VOICES; v++) begin
            vstate_d[v] = vstate_q[v];
            acc_d[v]    = acc_q[v];
            inc_d[v]    = inc_q[v];
            if (fsm_q == S_ISSUE && idx_q == IDX_W'(v) && vstate_q[v] != V_IDLE) begin
                acc_d[v] = acc_q[v] + inc_q[v];
                if (vstate_q[v] == V_FRONT && acc_wraps(acc_q[v], inc_q[v]))
                    vstate_d[v] = V_BACK;
            end
            if (note_off && voice_id == IDX_W'(v)) begin
                vstate_d[v] = V_IDLE;
            end else if (note_on && voice_id == IDX_W'(v)) begin
                vstate_d[v] = V_FRONT;
                acc_d[v]    = '0;
                inc_d[v]    = increment;
            end
        end
    end

    // The table address is loaded one cycle early so it is valid during the ISSUE cycle itself.
    always_comb begin
        pre_en  = 1'b0;
        pre_idx = '0;
        if (fsm_q == S_WAIT && sample_tick) begin
            pre_en  = 1'b1;
            pre_idx = '0;
        end else if (fsm_q == S_ISSUE && idx_q != LAST_IDX) begin
            pre_en  = 1'b1;
            pre_idx = idx_q + IDX_W'(1);
        end
    end

    always_comb begin
        cap_val = '0;
        if (cap_vld_q)
            cap_val = {{IDX_W{table_sample[AUDIO_WIDTH-1]}}, table_sample};
        sum_next = sum_q + cap_val;
    end

    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                vstate_q[v] <= V_IDLE;
                acc_q[v]    <= '0;
                inc_q[v]    <= '0;
            end
        end else begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                vstate_q[v] <= vstate_d[v];
                acc_q[v]    <= acc_d[v];
                inc_q[v]    <= inc_d[v];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            fsm_q         <= S_WAIT;
            idx_q         <= '0;
            sum_q         <= '0;
            cap_vld_q     <= 1'b0;
            busy_q        <= 1'b0;
            overrun_q     <= 1'b0;
            mix_valid_q   <= 1'b0;
            mix_q         <= '0;
            table_state_q <= TS_FRONT;
            table_phase_q <= '0;
        end else begin
            mix_valid_q <= 1'b0;
            if (sample_tick && busy_q)
                overrun_q <= 1'b1;
            if (pre_en) begin
                table_state_q <= (vstate_d[pre_idx] == V_BACK) ? TS_BACK : TS_FRONT;
                table_phase_q <= acc_d[pre_idx][ACC_WIDTH-1 -: PHASE_WIDTH];
            end
            case (fsm_q)
                S_WAIT: begin
                    cap_vld_q <= 1'b0;
                    if (sample_tick) begin
                        fsm_q  <= S_ISSUE;
                        idx_q  <= '0;
                        sum_q  <= '0;
                        busy_q <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    sum_q     <= sum_next;
                    cap_vld_q <= (vstate_q[idx_q] != V_IDLE);
                    if (idx_q == LAST_IDX)
                        fsm_q <= S_DRAIN;
                    else
                        idx_q <= idx_q + IDX_W'(1);
                end
                S_DRAIN: begin
                    mix_q       <= mix_scale(sum_next);
                    mix_valid_q <= 1'b1;
                    busy_q      <= 1'b0;
                    cap_vld_q   <= 1'b0;
                    fsm_q       <= S_WAIT;
                end
                default: fsm_q <= S_WAIT;
            endcase
        end
    end

    assign table_state = table_state_q;
    assign table_phase = table_phase_q;
    assign mix         = mix_q;
    assign mix_valid   = mix_valid_q;
    assign busy        = busy_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_trumpet_voice_scheduler.sv
// Bench for trumpet_voice_scheduler: a 4-voice instance checked against a sweep-level model, plus a 2-voice instance for mix range limits.
module tb_trumpet_voice_scheduler;
    localparam int NV = 4;
    localparam int AW = 24;
    localparam int PW = 12;
    localparam int DW = 16;
`ifdef TRUMPET_SCHED_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic                 reset_l;
    logic                 tick, non, noff;
    logic [1:0]           vid;
    logic [AW-1:0]        inc;
    logic                 tstate;
    logic [PW-1:0]        tphase;
    logic signed [DW-1:0] tsample, mix;
    logic                 mix_valid, busy, overrun;

    logic                 tick2, non2, noff2;
    logic [0:0]           vid2;
    logic [AW-1:0]        inc2;
    logic                 tstate2;
    logic [PW-1:0]        tphase2;
    logic signed [DW-1:0] tsample2, mix2, const2;
    logic                 mv2, busy2, ovr2;

    trumpet_voice_scheduler #(.NUM_VOICES(NV), .ACC_WIDTH(AW), .PHASE_WIDTH(PW), .AUDIO_WIDTH(DW)) dut (
        .clock(clock), .reset_l(reset_l), .sample_tick(tick), .note_on(non), .note_off(noff),
        .voice_id(vid), .increment(inc), .table_state(tstate), .table_phase(tphase),
        .table_sample(tsample), .mix(mix), .mix_valid(mix_valid), .busy(busy), .overrun(overrun));

    trumpet_voice_scheduler #(.NUM_VOICES(2), .ACC_WIDTH(AW), .PHASE_WIDTH(PW), .AUDIO_WIDTH(DW)) dut2 (
        .clock(clock), .reset_l(reset_l), .sample_tick(tick2), .note_on(non2), .note_off(noff2),
        .voice_id(vid2), .increment(inc2), .table_state(tstate2), .table_phase(tphase2),
        .table_sample(tsample2), .mix(mix2), .mix_valid(mv2), .busy(busy2), .overrun(ovr2));

    int                   tab_mode;
    logic signed [DW-1:0] const_val;

    function automatic logic signed [DW-1:0] tab_fn(input logic st, input logic [PW-1:0] ph);
        int r;
        if (tab_mode == 0) return const_val;
        r = st ? 1000 - 7 * int'(ph) : 5 * int'(ph) - 7000;
        return DW'(r);
    endfunction

    // Trumpet stand-ins: one-cycle registered table reads.
    always_ff @(posedge clock) begin
        tsample  <= tab_fn(tstate, tphase);
        tsample2 <= const2;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Sweep-level reference: voice states 0=idle 1=front 2=back.
    int                   m_state [NV];
    logic [AW-1:0]        m_acc   [NV];
    logic [AW-1:0]        m_inc   [NV];
    logic [PW-1:0]        e_ph    [NV];
    logic                 e_bk    [NV];
    bit                   e_act   [NV];
    logic signed [DW-1:0] e_mix;
    logic [PW-1:0]        obs_ph  [NV];
    logic                 obs_bk  [NV];

    function automatic logic signed [DW-1:0] scale(input longint s);
        longint r;
        if (SAT) r = (s > 32767) ? 32767 : ((s < -32768) ? -32768 : s);
        else     r = s >>> $clog2(NV);
        return DW'(r);
    endfunction

    task automatic model_reset();
        for (int v = 0; v < NV; v++) begin
            m_state[v] = 0; m_acc[v] = '0; m_inc[v] = '0;
        end
    endtask

    task automatic model_note(input logic on, input logic off, input int v, input logic [AW-1:0] in);
        if (off) m_state[v] = 0;
        else if (on) begin m_state[v] = 1; m_acc[v] = '0; m_inc[v] = in; end
    endtask

    task automatic model_sweep();
        longint s;
        longint nxt;
        s = 0;
        for (int v = 0; v < NV; v++) begin
            e_act[v] = (m_state[v] != 0);
            e_ph[v]  = m_acc[v][AW-1 -: PW];
            e_bk[v]  = (m_state[v] == 2);
            if (e_act[v]) begin
                s += tab_fn(e_bk[v], e_ph[v]);
                nxt = longint'(m_acc[v]) + longint'(m_inc[v]);
                if (nxt >= (longint'(1) << AW) && m_state[v] == 1) m_state[v] = 2;
                m_acc[v] = AW'(nxt);
            end
        end
        e_mix = scale(s);
    endtask

    task automatic note(input logic on, input logic off, input int v, input logic [AW-1:0] in);
        non = on; noff = off; vid = 2'(v); inc = in;
        cyc();
        non = 1'b0; noff = 1'b0;
        model_note(on, off, v, in);
    endtask

    // One full sweep; optionally a note event for the voice being issued at index inj_idx.
    task automatic sweep(input int inj_idx, input logic inj_on, input logic inj_off,
                         input logic [AW-1:0] inj_inc, input string tag);
        model_sweep();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        for (int i = 0; i < NV; i++) begin
            obs_ph[i] = tphase;
            obs_bk[i] = tstate;
            if (e_act[i]) begin
                chk({tag, " phase"}, tphase, e_ph[i]);
                chk({tag, " state"}, tstate, e_bk[i]);
            end
            if (i == inj_idx) begin
                non = inj_on; noff = inj_off; vid = 2'(i); inc = inj_inc;
            end
            cyc();
            non = 1'b0; noff = 1'b0;
        end
        chk({tag, " drain busy"}, busy, 1);
        chk({tag, " early valid"}, mix_valid, 0);
        cyc();
        chk({tag, " valid"}, mix_valid, 1);
        chk({tag, " mix"}, mix, e_mix);
        chk({tag, " busy done"}, busy, 0);
        if (inj_idx >= 0) model_note(inj_on, inj_off, inj_idx, inj_inc);
        cyc();
        chk({tag, " valid pulse"}, mix_valid, 0);
    endtask

    typedef struct {
        logic signed [DW-1:0] val;
        logic signed [DW-1:0] exp_div;
        logic signed [DW-1:0] exp_sat;
    } vec_t;
    vec_t vt [6];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int pulses;
        logic signed [DW-1:0] last_mix;

        vt[0] = '{16'sh7FFF, 16'sh7FFF, 16'sh7FFF};
        vt[1] = '{16'sh8000, 16'sh8000, 16'sh8000};
        vt[2] = '{16'sd20000, 16'sd20000, 16'sh7FFF};
        vt[3] = '{-16'sd20000, -16'sd20000, 16'sh8000};
        vt[4] = '{16'sd100, 16'sd100, 16'sd200};
        vt[5] = '{-16'sd3, -16'sd3, -16'sd6};

        reset_l = 1'b1; tick = 0; non = 0; noff = 0; vid = '0; inc = '0;
        tick2 = 0; non2 = 0; noff2 = 0; vid2 = '0; inc2 = '0; const2 = '0;
        tab_mode = 0; const_val = '0;
        model_reset();
        #3 reset_l = 1'b0;
        repeat (3) cyc();
        chk("rst mix", mix, 0);
        chk("rst mix_valid", mix_valid, 0);
        chk("rst busy", busy, 0);
        chk("rst overrun", overrun, 0);
        chk("rst table_state", tstate, 0);
        chk("rst table_phase", tphase, 0);
        reset_l = 1'b1;
        cyc();

        // Two-voice instance: mix range limits.
        for (int v = 0; v < 2; v++) begin
            non2 = 1'b1; vid2 = 1'(v); inc2 = '0;
            cyc();
        end
        non2 = 1'b0;
        for (int k = 0; k < 6; k++) begin
            const2 = vt[k].val;
            cyc();
            tick2 = 1'b1;
            cyc();
            tick2 = 1'b0;
            repeat (2) cyc();
            chk("n2 early valid", mv2, 0);
            cyc();
            chk("n2 valid", mv2, 1);
            chk("n2 mix", mix2, SAT ? vt[k].exp_sat : vt[k].exp_div);
        end
        chk("n2 busy", busy2, 0);
        chk("n2 overrun", ovr2, 0);
        chk("n2 table_phase", tphase2, 0);
        chk("n2 table_state", tstate2, 0);

        // Idle sweep.
        sweep(-1, 0, 0, '0, "idle");
        chk("idle mix", mix, 0);

        // Single voice, quarter-range increment, constant table.
        const_val = 16'sd400;
        note(1, 0, 2, 24'h400000);
        for (int k = 0; k < 5; k++) begin
            sweep(-1, 0, 0, '0, "quarter");
            chk("quarter phase seq", obs_ph[2], (k * 1024) % 4096);
            chk("quarter section", obs_bk[2], (k == 4) ? 1 : 0);
            chk("quarter mix", mix, SAT ? 400 : 100);
        end
        note(0, 1, 2, '0);
        sweep(-1, 0, 0, '0, "noteoff");
        chk("noteoff mix", mix, 0);

        // Second sample_tick while busy.
        tab_mode = 1;
        note(1, 0, 0, 24'h1357AB);
        note(1, 0, 3, 24'hC0FFEE);
        chk("pre overrun", overrun, 0);
        model_sweep();
        tick = 1'b1; cyc(); tick = 1'b0; cyc();
        tick = 1'b1; cyc(); tick = 1'b0;
        pulses = 0; last_mix = '0;
        for (int c = 0; c < 3 * NV; c++) begin
            if (mix_valid) begin pulses++; last_mix = mix; end
            cyc();
        end
        chk("overrun pulses", pulses, 1);
        chk("overrun mix", last_mix, e_mix);
        chk("overrun set", overrun, 1);
        sweep(-1, 0, 0, '0, "post overrun");
        chk("overrun sticky", overrun, 1);

        // note_on in the cycle its voice is issued.
        note(1, 0, 1, 24'hA00000);
        sweep(-1, 0, 0, '0, "inj pre");
        sweep(-1, 0, 0, '0, "inj pre");
        sweep(1, 1, 0, 24'h0F0F0F, "inj");
        chk("inj old phase", obs_ph[1], 12'h400);
        chk("inj old section", obs_bk[1], 1);
        sweep(-1, 0, 0, '0, "inj post");
        chk("inj restart phase", obs_ph[1], 0);
        chk("inj restart section", obs_bk[1], 0);

        // Reset in the middle of a sweep.
        tick = 1'b1; cyc(); tick = 1'b0; cyc();
        reset_l = 1'b0;
        #1;
        chk("midrst busy", busy, 0);
        chk("midrst mix", mix, 0);
        chk("midrst overrun", overrun, 0);
        chk("midrst table_phase", tphase, 0);
        chk("midrst table_state", tstate, 0);
        cyc();
        reset_l = 1'b1;
        model_reset();
        pulses = 0;
        for (int c = 0; c < NV + 4; c++) begin
            cyc();
            if (mix_valid) pulses++;
        end
        chk("midrst no valid", pulses, 0);
        sweep(-1, 0, 0, '0, "midrst idle");

        // Randomized notes, increments and same-cycle events.
        for (int it = 0; it < 40; it++) begin
            int n;
            n = $urandom_range(0, 2);
            for (int e = 0; e < n; e++)
                note(($urandom % 4) != 0, ($urandom % 5) == 0, $urandom_range(0, NV - 1), AW'($urandom));
            if ($urandom % 4 == 0)
                sweep($urandom_range(0, NV - 1), ($urandom % 2) == 1, ($urandom % 4) == 0, AW'($urandom), "rnd inj");
            else
                sweep(-1, 0, 0, '0, "rnd");
            repeat ($urandom_range(0, 2)) cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/trumpet_voice_scheduler.md
Name: trumpet_voice_scheduler

Overview:
- Time-multiplexes one Trumpet table pair (front/back LUTs, 1-cycle registered read) across NUM_VOICES voices.
- Keeps per-voice phase accumulator and FRONT/BACK section state, and handles note on/off.
- On each audio sample tick, issues one table lookup per voice and mixes the returned samples into one output sample with a valid pulse.
- Sits between the MIDI/note front end and the audio output path.

Parameters:
- NUM_VOICES, 8, voice count; power of two, >= 2.
- ACC_WIDTH, 24, per-voice phase accumulator width.
- PHASE_WIDTH, CONFIG::LONG_PERCENT_WIDTH, table address width; table_phase = acc[ACC_WIDTH-1 -: PHASE_WIDTH].
- AUDIO_WIDTH, CONFIG::AUDIO_BIT_WIDTH, signed two's-complement sample width.

Ports:
- clock  in  1  system clock.
- reset_l  in  1  asynchronous, active-low reset.
- sample_tick  in  1  one-cycle pulse per audio sample period.
- note_on  in  1  start voice voice_id with increment.
- note_off  in  1  stop voice voice_id.
- voice_id  in  $clog2(NUM_VOICES)  target voice of note_on/note_off.
- increment  in  ACC_WIDTH  phase step per sample, latched on note_on.
- table_state  out  OSCILLATOR::oscillator_state_t  section select to Trumpet.
- table_phase  out  PHASE_WIDTH  table address to Trumpet.
- table_sample  in  AUDIO_WIDTH  Trumpet output, valid the cycle after the address.
- mix  out  AUDIO_WIDTH  mixed sample.
- mix_valid  out  1  one-cycle pulse when mix updates.
- busy  out  1  high while a sample sweep is in progress.
- overrun  out  1  sticky: a sample_tick arrived while busy.

Behaviour:
- Reset (async, reset_l=0): all voices IDLE, acc=0, inc=0; mix=0, mix_valid=0, busy=0, overrun=0, table_state=FRONT, table_phase=0; FSM enters WAIT.
- Per-voice state:
  - IDLE --note_on--> FRONT, acc=0, inc=increment.
  - FRONT --acc wraps on advance (carry out of ACC_WIDTH)--> BACK.
  - BACK --wrap--> BACK (loop).
  - Any state --note_off--> IDLE.
  - note_on to an active voice restarts it in FRONT with acc=0.
  - note_on and note_off asserted together: note_off wins.
- Scheduler FSM:
  - WAIT --sample_tick--> ISSUE with idx=0, sum=0, busy=1.
  - ISSUE: drive table_state/table_phase of voice idx. Then advance that voice (acc += inc mod 2^ACC_WIDTH, apply FRONT->BACK on wrap) if it is not IDLE. idx++. After idx=NUM_VOICES-1 go to DRAIN.
  - Capture: each cycle after an ISSUE, add sign-extended table_sample to sum if the voice issued in the previous cycle was non-IDLE at issue time; otherwise add 0.
  - DRAIN: perform the final capture, then go to WAIT. Next cycle: mix updates, mix_valid=1 for one cycle, busy=0.
- Latency: mix_valid is asserted exactly NUM_VOICES+2 cycles after the sample_tick cycle.
- sum width: AUDIO_WIDTH+$clog2(NUM_VOICES), signed. Default mix = sum >>> $clog2(NUM_VOICES), truncated to AUDIO_WIDTH (no overflow possible).
- A note event in the same cycle its voice is being issued: the issue uses the pre-event state/phase. The note event then overrides the advance (no acc increment is applied).
- sample_tick while busy: ignored, overrun set to 1; it stays set until reset.
- Between sweeps: table_state/table_phase hold their last values; mix holds.
- Reset mid-sweep: the sweep is abandoned with no mix_valid.

Optional Feature:
- Macro: TRUMPET_SCHED_SATURATE_EN.
- Defined: mix = sum saturated to the signed AUDIO_WIDTH range (no divide), giving full per-voice loudness with clipping.
- Undefined: the divide-by-NUM_VOICES behaviour above.

Test Plan:
- Reset: reset_l=0 during activity -> all outputs 0 immediately (async); after release, sample_tick with no notes -> mix_valid NUM_VOICES+2 cycles later, mix=0.
- NUM_VOICES=4, note_on voice 2 with increment 2^(ACC_WIDTH-2), table model returns 400 -> table_phase for voice 2 sequences 0, 1/4, 1/2, 3/4 of range over 4 ticks; mix=100 each tick.
- Same voice on the 4th tick -> acc wraps, table_state switches FRONT->BACK from the 5th issue; note_off -> contribution 0 from the next sweep.
- Two voices returning +2^(AUDIO_WIDTH-1)-1 each, NUM_VOICES=2 -> mix = 2^(AUDIO_WIDTH-1)-1. With TRUMPET_SCHED_SATURATE_EN -> mix saturates to the same max with no wrap; with -2^(AUDIO_WIDTH-1) inputs -> most negative value.
- sample_tick asserted again 2 cycles after the first -> overrun=1, only one mix_valid pulse; overrun stays 1 until reset.
- note_on voice 1 in the exact cycle voice 1 is issued -> issued phase is the old value, next sweep issues phase 0 in FRONT.
